// File: rtl/pipemdu_if.sv
// Issue/result bundle between the EXE stage and the multiply/divide unit.
// The EXE stage drives operations; the unit returns busy/done and HI/LO.
interface pipemdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/pipemdu.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module pipemdu (
    input  logic     clock,
    input  logic     resetn,
    pipemdu_if.slave mdu
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        neg_q;
    logic        rneg_q;
    logic        dz_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        calc_op;
    logic        mthi_op;
    logic        mtlo_op;

    assign sgn     = ~mdu.op[0];
    assign a_neg   = sgn & mdu.a[31];
    assign b_neg   = sgn & mdu.b[31];
    assign a_abs   = a_neg ? -mdu.a : mdu.a;
    assign b_abs   = b_neg ? -mdu.b : mdu.b;
    assign calc_op = ~mdu.op[2];
    assign mthi_op = mdu.op == 3'b100;
    assign mtlo_op = mdu.op == 3'b101;

    // Multiply step: acc holds {partial product, remaining multiplier}
    logic [32:0] msum_d;
    logic [63:0] mul_d;
    assign msum_d = {1'b0, acc_q[63:32]}
                  + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_d  = {msum_d, acc_q[31:1]};

    // Divide step: acc holds {partial remainder, dividend/quotient}
    logic [32:0] dshift_d;
    logic [32:0] dtrial_d;
    logic [63:0] div_d;
    assign dshift_d = {acc_q[63:32], acc_q[31]};
    assign dtrial_d = dshift_d - {1'b0, opnd_q};
    assign div_d    = dtrial_d[32]
                    ? {dshift_d[31:0], acc_q[30:0], 1'b0}
                    : {dtrial_d[31:0], acc_q[30:0], 1'b1};

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mdu.start) begin
                        unique case (1'b1)
                            calc_op: begin
                                acc_q    <= {32'd0, mdu.op[1] ? a_abs : b_abs};
                                opnd_q   <= mdu.op[1] ? b_abs : a_abs;
                                is_div_q <= mdu.op[1];
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                dz_q     <= mdu.b == 32'd0;
                                cnt_q    <= 6'd0;
                                busy_q   <= 1'b1;
                                state_q  <= CALC;
                            end
                            mthi_op: hi_q <= mdu.a;
                            mtlo_op: lo_q <= mdu.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_d : mul_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        lo_q <= dz_q ? 32'hFFFF_FFFF : quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: doc/pipemdu.md
# pipemdu

Iterative multiply/divide unit that serves the EXE stage of the five-stage pipeline. The EXE stage issues mult/multu/div/divu/mthi/mtlo operations with their operand values; this unit computes the result over multiple cycles into its HI/LO registers. It raises `busy` so the hazard logic can stall later mfhi/mflo or MDU instructions. The EXE stage is the initiator and this block is the responder.

## Interface

- No parameters. Width is fixed at 32 bits and the iteration count is fixed at 32.

- `clock` in 1: pipeline clock. All state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: issue strobe from EXE, one cycle per instruction. Sampled only when `busy`=0.
- `op` in 3: operation code.
  - 000 mult (signed)
  - 001 multu
  - 010 div (signed)
  - 011 divu
  - 100 mthi
  - 101 mtlo
  - 110/111 no-op
- `a` in 32: rs value, the multiplicand or dividend.
- `b` in 32: rt value, the multiplier or divisor. mthi/mtlo take their data from `a`.
- `busy` out 1: operation in progress. The pipeline stalls while high.
- `done` out 1: one-cycle pulse when HI/LO receive a mult/div result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation

- FSM has three states: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 with op 000–011: latch |a| and |b| for signed ops, or the raw values for unsigned ops. Latch the result signs, clear the 6-bit counter, go to CALC.
  - `start`=1 with op 100: `hi`<=`a`. op 101: `lo`<=`a`. These complete in one cycle, leave `busy` low and do not pulse `done`.
  - `start`=1 with op 110/111: ignored.
- **CALC**: performs one iteration per cycle for 32 cycles, then moves to FIX when the counter reaches 31.
  - Multiply: shift-add on a 64-bit accumulator, using the LSB of the multiplier.
  - Divide: restoring, one quotient bit per cycle, with a 33-bit trial subtract of the partial remainder minus the divisor.
- **FIX**: applies sign correction, writes `hi`/`lo`, pulses `done`, returns to IDLE.
- Result rules:
  - mult/multu: {hi,lo} = the 64-bit product. For mult, the product is negated when sign(a)≠sign(b).
  - div/divu: lo = quotient, hi = remainder. For signed div, the quotient is negated when sign(a)≠sign(b), and the remainder takes the sign of `a`.
  - Signed div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural mod-2^32 result and needs no special case.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=`a` (original signed value). It still takes the full 33-cycle latency.
- `start` while `busy`=1 is ignored entirely; HI/LO and the operation in progress are unaffected. The pipeline must hold the instruction, and must not rely on it being accepted.
- `hi`/`lo` hold their previous values throughout CALC. Intermediate results are never visible.

## Timing

- Reset (async, any state): state=IDLE, counter=0, `busy`=0, `done`=0, `hi`=0, `lo`=0, and all internal accumulators cleared. Reset mid-operation discards the operation and no `done` follows.
- Call the edge that accepts `start` edge E0.
  - `busy`=1 from after E0 until after E33, i.e. for 33 cycles.
  - CALC occupies edges E1–E32.
  - FIX is evaluated at E33: `hi`/`lo` are written, `busy` drops, and `done`=1 for exactly the cycle after E33.
- A new `start` is accepted at E34 at the earliest, i.e. in the same cycle `done` is high, since `busy` is already 0.
- mthi/mtlo: the register updates at E0 and is visible in the next cycle, with zero stall.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan

- Signed multiply: reset; mult `a`=0xFFFFFFFD (−3), `b`=5.
  - Required: `busy` high for 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, and `done` pulses once.
- Unsigned multiply: multu `a`=0xFFFFFFFF, `b`=0xFFFFFFFF.
  - Required: `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed divide: div `a`=0xFFFFFFF9 (−7), `b`=2.
  - Required: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Then divu `a`=100, `b`=7. Required: `lo`=14, `hi`=2.
- Divide by zero and overflow case:
  - divu `a`=100, `b`=0. Required: `lo`=0xFFFFFFFF, `hi`=100.
  - div 0x80000000 / 0xFFFFFFFF. Required: `lo`=0x80000000, `hi`=0.
- Moves and ignored start:
  - mthi `a`=0x12345678. Required: `hi` updated next cycle, `busy` stays 0.
  - Then mult 2×3, with a second `start` (mtlo 0xDEAD) issued mid-CALC. Required: mtlo ignored; final `hi`=0, `lo`=6.
- Reset abort: start divu 1000/3, assert `resetn`=0 at cycle 10 of CALC.
  - Required: `busy`, `done`, `hi` and `lo` all 0 immediately, and no `done` after release.
